// File: rtl/iob_sram_port_arb.sv
// Round-robin arbiter sharing one native-bus SRAM port among N_MASTERS requesters.
// Define IOB_SOC_SUT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module iob_sram_port_arb #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 15
) (
    input  logic                            clk_i,
    input  logic                            cke_i,
    input  logic                            arst_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]               m_rdata_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic                            s_ready_i,
    input  logic                            s_rvalid_i,
    input  logic [DATA_W-1:0]               s_rdata_i,
    output logic                            timeout_o
);

    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] owner, owner_nxt;
    logic [PW-1:0] base, sel;
    logic [CW-1:0] wait_cnt, wait_nxt;
    logic          found;

`ifdef IOB_SOC_SUT_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    logic [PW-1:0] ptr, ptr_nxt;
    assign base = ptr;
`endif

    // Scan requesters starting at the round-robin base, wrapping modulo N.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            idx = int'(base) + i;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && m_avalid_i[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    assign s_addr_o  = m_addr_i[int'(sel)*ADDR_W +: ADDR_W];
    assign s_wdata_o = m_wdata_i[int'(sel)*DATA_W +: DATA_W];
    assign s_wstrb_o = m_wstrb_i[int'(sel)*SW +: SW];
    assign m_rdata_o = s_rdata_i;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        wait_nxt   = wait_cnt;
`ifndef IOB_SOC_SUT_ARB_FIXED_PRIO_EN
        ptr_nxt    = ptr;
`endif
        s_avalid_o = 1'b0;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        timeout_o  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    s_avalid_o     = 1'b1;
                    m_ready_o[sel] = s_ready_i;
                    if (s_ready_i) begin
`ifndef IOB_SOC_SUT_ARB_FIXED_PRIO_EN
                        ptr_nxt = (sel == PW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
`endif
                        owner_nxt = sel;
                        if (s_wstrb_o == '0) begin
                            state_nxt = RD_WAIT;
                            wait_nxt  = '0;
                        end
                    end
                end
            end
            RD_WAIT: begin
                m_rvalid_o[owner] = s_rvalid_i;
                if (s_rvalid_i) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == CW'(MAX_WAIT)) begin
                    state_nxt = IDLE;
                    timeout_o = cke_i;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are quiet while reset is held, even with requests pending.
        if (arst_i) begin
            s_avalid_o = 1'b0;
            m_ready_o  = '0;
            m_rvalid_o = '0;
            timeout_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state    <= IDLE;
            owner    <= '0;
            wait_cnt <= '0;
`ifndef IOB_SOC_SUT_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else if (cke_i) begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            wait_cnt <= wait_nxt;
`ifndef IOB_SOC_SUT_ARB_FIXED_PRIO_EN
            ptr      <= ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_iob_sram_port_arb.sv
// Bench for iob_sram_port_arb: directed vector table, hand sequences,
// then random traffic checked against a queue-free behavioural model.
module tb_iob_sram_port_arb;

    localparam int N = 2;
    localparam int MW = 15;
    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0040;
    localparam logic [31:0] RD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic cke, arst;
    logic [N-1:0] m_avalid, m_ready, m_rvalid;
    logic [N*32-1:0] m_addr, m_wdata;
    logic [N*4-1:0] m_wstrb;
    logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0] s_wstrb;
    logic s_avalid, s_ready, s_rvalid, timeout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    iob_sram_port_arb #(.N_MASTERS(N), .ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_wstrb_i(m_wstrb), .m_ready_o(m_ready), .m_rvalid_o(m_rvalid),
        .m_rdata_o(m_rdata), .s_avalid_o(s_avalid), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_ready_i(s_ready),
        .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .timeout_o(timeout)
    );

    typedef struct {
        bit rst; bit [1:0] av; bit [1:0] wr; bit rdy; bit rv;
        bit e_av; bit [1:0] e_rdy; bit [1:0] e_rv; bit e_to; logic [31:0] e_addr;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(bit rst, bit [1:0] av, bit [1:0] wr, bit rdy, bit rv,
                                bit e_av, bit [1:0] e_rdy, bit [1:0] e_rv, bit e_to,
                                logic [31:0] e_addr);
        vec_t v;
        v.rst = rst; v.av = av; v.wr = wr; v.rdy = rdy; v.rv = rv;
        v.e_av = e_av; v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_to = e_to; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One directed cycle: drive after the edge, check mid-cycle.
    task automatic cyc(input string nm, input vec_t v);
        @(posedge clk);
        #1;
        arst = v.rst;
        cke = 1'b1;
        m_avalid = v.av;
        m_addr = {A1, A0};
        m_wdata = {32'h1111_1111, 32'h0000_0000};
        m_wstrb = {v.wr[1] ? 4'hF : 4'h0, v.wr[0] ? 4'hF : 4'h0};
        s_ready = v.rdy;
        s_rvalid = v.rv;
        s_rdata = RD;
        #3;
        chk({nm, "_ctl"}, {s_avalid, m_ready, m_rvalid, timeout},
            {v.e_av, v.e_rdy, v.e_rv, v.e_to});
        if (v.e_av) chk({nm, "_addr"}, s_addr, v.e_addr);
        if (v.e_rv != 2'b00) chk({nm, "_rdata"}, m_rdata, RD);
    endtask

    // Reference model state: next round-robin start, busy-with-read, owner, cycles waited.
    int rr, owner, waited, sel;
    bit busy;
    logic [31:0] ra[N], rw[N];
    logic [3:0] rs[N];

    initial begin
        bit e_av, e_to;
        bit [1:0] e_rdy, e_rv;
        bit rst, rdy, rv;
        bit [1:0] av;

        arst = 1'b1; cke = 1'b1; m_avalid = '0; m_addr = '0; m_wdata = '0;
        m_wstrb = '0; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;

        tbl[0]  = mk(1, 2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, '0);
        tbl[1]  = mk(1, 2'b11, 2'b11, 1, 0, 0, 2'b00, 2'b00, 0, '0);
        tbl[2]  = mk(0, 2'b11, 2'b11, 1, 0, 1, 2'b01, 2'b00, 0, A0);
        tbl[3]  = mk(0, 2'b11, 2'b11, 1, 0, 1, 2'b10, 2'b00, 0, A1);
        tbl[4]  = tbl[2];
        tbl[5]  = tbl[3];
        tbl[6]  = tbl[2];
        tbl[7]  = tbl[3];
        tbl[8]  = mk(0, 2'b10, 2'b01, 1, 0, 1, 2'b10, 2'b00, 0, A1);
        tbl[9]  = mk(0, 2'b11, 2'b01, 1, 0, 0, 2'b00, 2'b00, 0, '0);
        tbl[10] = mk(0, 2'b11, 2'b01, 1, 1, 0, 2'b00, 2'b10, 0, '0);
        tbl[11] = mk(0, 2'b01, 2'b01, 1, 0, 1, 2'b01, 2'b00, 0, A0);
        tbl[12] = mk(0, 2'b01, 2'b01, 0, 0, 1, 2'b00, 2'b00, 0, A0);
        tbl[13] = tbl[12];
        tbl[14] = tbl[12];
        tbl[15] = mk(0, 2'b01, 2'b01, 1, 0, 1, 2'b01, 2'b00, 0, A0);
        tbl[16] = mk(0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, '0);

        for (int i = 0; i < 17; i++) cyc($sformatf("vec%0d", i), tbl[i]);

        // Read timeout: 16 cycles in the wait state, pulse on the last.
        cyc("to_rst", mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, '0));
        cyc("to_acc", mk(0, 2'b01, 2'b00, 1, 0, 1, 2'b01, 2'b00, 0, A0));
        for (int k = 0; k <= MW; k++)
            cyc($sformatf("to_wait%0d", k),
                mk(0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, k == MW, '0));
        cyc("to_late", mk(0, 2'b01, 2'b01, 0, 1, 1, 2'b00, 2'b00, 0, A0));

        // Reset in the middle of a read drops the response.
        cyc("mr_rst0", mk(1, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, '0));
        cyc("mr_acc", mk(0, 2'b10, 2'b00, 1, 0, 1, 2'b10, 2'b00, 0, A1));
        cyc("mr_wait", mk(0, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, '0));
        cyc("mr_rst1", mk(1, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, '0));
        cyc("mr_late", mk(0, 2'b00, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, '0));
        cyc("mr_ptr0", mk(0, 2'b11, 2'b11, 1, 0, 1, 2'b01, 2'b00, 0, A0));

        // Random traffic against the reference model.
        rr = 0; busy = 0; owner = 0; waited = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 0) || ($urandom_range(0, 63) == 0);
            av = 2'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                ra[i] = $urandom;
                rw[i] = $urandom;
                rs[i] = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            arst = rst; cke = 1'b1; m_avalid = av; s_ready = rdy; s_rvalid = rv;
            s_rdata = $urandom;
            m_addr = {ra[1], ra[0]};
            m_wdata = {rw[1], rw[0]};
            m_wstrb = {rs[1], rs[0]};

            e_av = 0; e_rdy = '0; e_rv = '0; e_to = 0; sel = -1;
            if (!rst) begin
                if (!busy) begin
                    for (int k = 0; k < N; k++)
                        if (sel < 0 && av[(rr + k) % N]) sel = (rr + k) % N;
                    if (sel >= 0) begin
                        e_av = 1;
                        e_rdy[sel] = rdy;
                    end
                end else begin
                    e_rv[owner] = rv;
                    e_to = !rv && (waited == MW);
                end
            end
            #3;
            chk($sformatf("rnd%0d_ctl", c), {s_avalid, m_ready, m_rvalid, timeout},
                {e_av, e_rdy, e_rv, e_to});
            if (e_av)
                chk($sformatf("rnd%0d_bus", c), {s_addr, s_wdata, s_wstrb},
                    {ra[sel], rw[sel], rs[sel]});
            if (e_rv != 2'b00) chk($sformatf("rnd%0d_rdata", c), m_rdata, s_rdata);

            if (rst) begin
                rr = 0; busy = 0; owner = 0; waited = 0;
            end else if (!busy) begin
                if (sel >= 0 && rdy) begin
                    rr = (sel + 1) % N;
                    owner = sel;
                    if (rs[sel] == 4'h0) begin
                        busy = 1;
                        waited = 0;
                    end
                end
            end else if (rv || waited == MW) begin
                busy = 0;
            end else begin
                waited++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
